// File: rtl/mem_access.sv
// Memory-access stage: registers one load/store and drives a simple req/ack data bus.
// It also returns load data or passes a non-memory result through, and aborts after TIMEOUT_CYCLES.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them down.
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_i,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        err
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d, lane_q, lane_d;
  logic        uns_q, uns_d, ld_q, ld_d;
  logic [4:0]  dest_q, dest_d;
  logic        stall_q, stall_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        wb_valid_q, wb_valid_d, err_q, err_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        accept, trap, acc_uns;
  logic [1:0]  acc_size, acc_lane;

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    store_be = 4'b0001 << lane;
      2'd1:    store_be = lane[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'd0:    store_wdata = {4{d[7:0]}};
      2'd1:    store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lane, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lane, 3'b000};
    case (size)
      2'd0:    load_ext = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    load_ext = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = rdata;
    endcase
  endfunction

  // Decode access width/sign; store codes 100/101 are undefined and fall back to word.
  always_comb begin
    acc_size = 2'd2;
    acc_uns  = 1'b0;
    case (func3)
      3'b000:  begin acc_size = 2'd0; acc_uns = 1'b0; end
      3'b001:  begin acc_size = 2'd1; acc_uns = 1'b0; end
      3'b100:  begin acc_size = is_store ? 2'd2 : 2'd0; acc_uns = ~is_store; end
      3'b101:  begin acc_size = is_store ? 2'd2 : 2'd1; acc_uns = ~is_store; end
      default: begin acc_size = 2'd2; acc_uns = 1'b0; end
    endcase
    case (acc_size)
      2'd0:    acc_lane = result[1:0];
      2'd1:    acc_lane = {result[1], 1'b0};
      default: acc_lane = 2'b00;
    endcase
  end

  assign accept = (state_q == IDLE) && (is_load || is_store);

`ifdef MEM_MISALIGN_TRAP_EN
  // Misaligned half/word accesses are refused rather than aligned down.
  always_comb begin
    if (acc_size == 2'd1) trap = result[0];
    else if (acc_size == 2'd2) trap = (result[1:0] != 2'b00);
    else trap = 1'b0;
  end
`else
  assign trap = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    ld_d        = ld_q;
    dest_d      = dest_q;
    stall_d     = stall_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        stall_d   = 1'b0;
        mem_req_d = 1'b0;
        if (accept && trap) begin
          err_d = 1'b1;
        end else if (accept) begin
          state_d     = BUSY;
          cnt_d       = 8'd0;
          stall_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = {result[31:2], 2'b00};
          mem_be_d    = is_store ? store_be(acc_size, acc_lane) : 4'b1111;
          mem_wdata_d = is_store ? store_wdata(acc_size, store_data) : 32'd0;
          size_d      = acc_size;
          lane_d      = acc_lane;
          uns_d       = acc_uns;
          ld_d        = ~is_store;
          dest_d      = dest_i;
        end else begin
          wb_valid_d = (dest_i != 5'd0);
          wb_dest_d  = dest_i;
          wb_data_d  = result;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          stall_d   = 1'b0;
          mem_req_d = 1'b0;
          if (ld_q && (dest_q != 5'd0)) begin
            wb_valid_d = 1'b1;
            wb_dest_d  = dest_q;
            wb_data_d  = load_ext(size_q, uns_q, lane_q, mem_rdata);
          end else begin
            wb_valid_d = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          stall_d   = 1'b0;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      size_q      <= 2'd0;
      lane_q      <= 2'd0;
      uns_q       <= 1'b0;
      ld_q        <= 1'b0;
      dest_q      <= 5'd0;
      stall_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= 5'd0;
      wb_data_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      ld_q        <= ld_d;
      dest_q      <= dest_d;
      stall_q     <= stall_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  assign stall     = stall_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed ops push expected writeback/err events,
// a negedge monitor pops and compares them; bus fields are checked during each BUSY cycle.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset, is_load, is_store, mem_ack;
  logic [2:0]  func3;
  logic [31:0] result, store_data, mem_rdata;
  logic [4:0]  dest_i;
  logic        stall, mem_req, mem_we, wb_valid, err;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_dest;

  typedef struct {bit is_err; logic [4:0] dest; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .is_load(is_load), .is_store(is_store), .func3(func3),
    .result(result), .store_data(store_data), .dest_i(dest_i), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .wb_dest(wb_dest), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] d, input logic [31:0] v);
    exp_t e;
    e.is_err = 1'b0; e.dest = d; e.data = v;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.dest = 5'd0; e.data = 32'd0;
    exp_q.push_back(e);
  endtask

  // Monitor: every writeback or err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (wb_valid || err)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {wb_valid, err, 30'd0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {31'd0, err}, {31'd0, e.is_err});
        chk("event_wb_valid", {31'd0, wb_valid}, {31'd0, ~e.is_err});
        if (!e.is_err) begin
          chk("wb_dest", {27'd0, wb_dest}, {27'd0, e.dest});
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] sd, input logic [4:0] dst,
                        input int ack_at, input logic [31:0] rdata,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input int e_stall);
    int n_stall;
    n_stall = 0;
    @(negedge clk);
    is_load = ld; is_store = st; func3 = f3; result = res; store_data = sd; dest_i = dst;
    @(posedge clk);
    #1;
    is_load = 1'b0; is_store = 1'b0; result = 32'd0; dest_i = 5'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) break;
      n_stall++;
      chk("busy_mem_req", {31'd0, mem_req}, 32'd1);
      chk("busy_mem_we", {31'd0, mem_we}, {31'd0, st});
      chk("busy_mem_addr", mem_addr, e_addr);
      chk("busy_mem_be", {28'd0, mem_be}, {28'd0, e_be});
      if (st) chk("busy_mem_wdata", mem_wdata, e_wdata);
      mem_ack = (k == ack_at);
      mem_rdata = rdata;
    end
    mem_ack = 1'b0;
    chk("stall_cycles", n_stall, e_stall);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic pass_through(input logic [31:0] res, input logic [4:0] dst);
    if (dst != 5'd0) push_wb(dst, res);
    @(negedge clk);
    result = res; dest_i = dst;
    @(posedge clk);
    #1;
    result = 32'd0; dest_i = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; is_load = 1'b0; is_store = 1'b0; func3 = 3'd0; result = 32'd0;
    store_data = 32'd0; dest_i = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {26'd0, stall, mem_req, mem_we, wb_valid, err, 1'b0}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_be_dest", {23'd0, mem_be, wb_dest}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    reset = 1'b0;

    // SW, ack in third BUSY cycle
    run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 2, 32'd0, 32'h100, 4'b1111, 32'hDEADBEEF, 3);
    // LB / LBU from lane 3
    push_wb(5'd5, 32'hFFFFFF80);
    run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd5, 1, 32'h80FF0000, 32'h100, 4'b1111, 32'd0, 2);
    push_wb(5'd5, 32'h00000080);
    run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 5'd5, 0, 32'h80FF0000, 32'h100, 4'b1111, 32'd0, 1);
    // SB lane 2, SH upper half
    run_op(1'b0, 1'b1, 3'b000, 32'h102, 32'h000000AB, 5'd0, 0, 32'd0, 32'h100, 4'b0100, 32'hABABABAB, 1);
    run_op(1'b0, 1'b1, 3'b001, 32'h106, 32'h1234CDEF, 5'd0, 1, 32'd0, 32'h104, 4'b1100, 32'hCDEFCDEF, 2);
    // LH upper half sign-extended, LHU lower half
    push_wb(5'd3, 32'hFFFF8001);
    run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 5'd3, 0, 32'h80017FFF, 32'h100, 4'b1111, 32'd0, 1);
    push_wb(5'd6, 32'h00007FFF);
    run_op(1'b1, 1'b0, 3'b101, 32'h100, 32'd0, 5'd6, 0, 32'h80017FFF, 32'h100, 4'b1111, 32'd0, 1);
    // Timeout after 4 BUSY cycles
    push_err();
    run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'd0, 5'd2, -1, 32'd0, 32'h40, 4'b1111, 32'd0, 4);
    // Load+store together is a store: no writeback
    run_op(1'b1, 1'b1, 3'b010, 32'h80, 32'h11223344, 5'd8, 0, 32'hFFFFFFFF, 32'h80, 4'b1111, 32'h11223344, 1);
    // Load to x0 accesses memory without writeback
    run_op(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 5'd0, 0, 32'h87654321, 32'h10, 4'b1111, 32'd0, 1);
    // Undefined func3 behaves as word
    push_wb(5'd10, 32'hA5A55A5A);
    run_op(1'b1, 1'b0, 3'b011, 32'h20, 32'd0, 5'd10, 0, 32'hA5A55A5A, 32'h20, 4'b1111, 32'd0, 1);
    // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
    push_err();
    run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 5'd11, 0, 32'h12345678, 32'h100, 4'b1111, 32'd0, 0);
`else
    push_wb(5'd11, 32'h12345678);
    run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 5'd11, 0, 32'h12345678, 32'h100, 4'b1111, 32'd0, 1);
`endif
    // Pass-through with and without destination
    pass_through(32'h000055AA, 5'd7);
    pass_through(32'h12340000, 5'd0);
    pass_through(32'hFFFF0001, 5'd31);

    // Reset in BUSY, then a late ack
    @(negedge clk);
    is_load = 1'b1; func3 = 3'b010; result = 32'h200; dest_i = 5'd9;
    @(posedge clk);
    #1;
    is_load = 1'b0; result = 32'd0; dest_i = 5'd0;
    @(negedge clk);
    chk("pre_reset_busy", {30'd0, stall, mem_req}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_ctrl", {26'd0, stall, mem_req, mem_we, wb_valid, err, 1'b0}, 32'd0);
    chk("midreset_addr", mem_addr, 32'd0);
    chk("midreset_be", {28'd0, mem_be}, 32'd0);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_ignored", {30'd0, stall, mem_req}, 32'd0);
    push_wb(5'd4, 32'hCAFEF00D);
    run_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd4, 0, 32'hCAFEF00D, 32'h300, 4'b1111, 32'd0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
